// File: rtl/video_scaler_pkg.sv
// Shared types and helpers for the video scaler blocks.
package video_scaler_pkg;

   typedef enum logic [1:0] {
      ST_LOCK,
      ST_PASS_A,
      ST_FETCH,
      ST_PASS_B
   } state_e;

   localparam logic COPY_FIRST  = 1'b0;
   localparam logic COPY_SECOND = 1'b1;

   function automatic int unsigned addr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/video_line_buffer.sv
// Simple dual-port line RAM: one write port, one synchronous read port (1-cycle latency).
module video_line_buffer
   import video_scaler_pkg::*;
#(
   parameter int unsigned D_WIDTH  = 8,
   parameter int unsigned MAX_LINE = 1024
) (
   input  logic                               clk_i,
   input  logic                               wr_en_i,
   input  logic [addr_width(MAX_LINE)-1:0]    wr_addr_i,
   input  logic [D_WIDTH-1:0]                 wr_data_i,
   input  logic                               rd_en_i,
   input  logic [addr_width(MAX_LINE)-1:0]    rd_addr_i,
   output logic [D_WIDTH-1:0]                 rd_data_o
);

   logic [D_WIDTH-1:0] mem_q [MAX_LINE];

   always_ff @(posedge clk_i) begin
      if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
   end

   // Read data holds its value until the next read is issued.
   always_ff @(posedge clk_i) begin
      if (rd_en_i) rd_data_o <= mem_q[rd_addr_i];
   end

endmodule

// File: rtl/video_upscaler_2x2.sv
// Streaming 2x2 pixel-replication upscaler (live line + replay from line buffer).
// Optional start-of-frame lock: define VIDEO_UPSCALER_FRAMELOCK_EN.
module video_upscaler_2x2
   import video_scaler_pkg::*;
#(
   parameter int unsigned D_WIDTH  = 8,
   parameter int unsigned MAX_LINE = 1024
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [D_WIDTH-1:0] up_data,
   input  logic               up_tuser,
   input  logic               up_tlast,
   input  logic               up_valid,
   output logic               up_ready,
   output logic [D_WIDTH-1:0] down_data,
   output logic               down_tuser,
   output logic               down_tlast,
   output logic               down_valid,
   input  logic               down_ready,
   output logic               err_overflow
);

   localparam int unsigned AW = addr_width(MAX_LINE);
   localparam int unsigned PW = AW + 1;
   localparam logic [PW-1:0] MAX_PTR = PW'(MAX_LINE);

`ifdef VIDEO_UPSCALER_FRAMELOCK_EN
   localparam state_e RESET_STATE = ST_LOCK;
`else
   localparam state_e RESET_STATE = ST_PASS_A;
`endif

   state_e             st_q;
   logic [D_WIDTH-1:0] data_q;
   logic               tuser_q, tlast_q, valid_q, copy_q, err_q;
   logic [PW-1:0]      wr_ptr_q, rd_ptr_q, len_q;

   logic               down_fire, up_fire, accept_line, line_a_done;
   logic [PW-1:0]      rd_next;
   logic               ram_we, ram_re;
   logic [AW-1:0]      ram_raddr;
   logic [D_WIDTH-1:0] ram_rdata;

   always_comb begin
      up_ready = 1'b0;
      unique case (st_q)
         ST_LOCK:   up_ready = 1'b1;
         // Bypass lets a new pixel load on the second-copy transfer, except at end of line.
         ST_PASS_A: up_ready = !valid_q | (copy_q & down_ready & !tlast_q);
         default:   up_ready = 1'b0;
      endcase
   end

   assign down_fire   = valid_q & down_ready;
   assign up_fire     = up_valid & up_ready;
   assign accept_line = up_fire & ((st_q == ST_PASS_A) | ((st_q == ST_LOCK) & up_tuser));
   assign line_a_done = (st_q == ST_PASS_A) & down_fire & (copy_q == COPY_SECOND) & tlast_q;
   assign rd_next     = rd_ptr_q + PW'(1);

   assign ram_we    = accept_line & (wr_ptr_q < MAX_PTR);
   // Address 0 is read as the live line closes so FETCH is the only bubble.
   assign ram_re    = line_a_done | ((st_q == ST_PASS_B) & down_fire & (copy_q == COPY_FIRST));
   assign ram_raddr = line_a_done ? '0 : rd_next[AW-1:0];

   video_line_buffer #(
      .D_WIDTH  (D_WIDTH),
      .MAX_LINE (MAX_LINE)
   ) u_line_buffer (
      .clk_i     (clk),
      .wr_en_i   (ram_we),
      .wr_addr_i (wr_ptr_q[AW-1:0]),
      .wr_data_i (up_data),
      .rd_en_i   (ram_re),
      .rd_addr_i (ram_raddr),
      .rd_data_o (ram_rdata)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q     <= RESET_STATE;
         data_q   <= '0;
         tuser_q  <= 1'b0;
         tlast_q  <= 1'b0;
         valid_q  <= 1'b0;
         copy_q   <= COPY_FIRST;
         err_q    <= 1'b0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         len_q    <= '0;
      end else begin
         unique case (st_q)
            ST_LOCK: ;
            ST_PASS_A: begin
               if (down_fire) begin
                  if (copy_q == COPY_FIRST) begin
                     copy_q <= COPY_SECOND;
                  end else begin
                     valid_q <= 1'b0;
                     copy_q  <= COPY_FIRST;
                     if (tlast_q) begin
                        len_q    <= wr_ptr_q;
                        rd_ptr_q <= '0;
                        st_q     <= ST_FETCH;
                     end
                  end
               end
            end
            ST_FETCH: begin
               data_q  <= ram_rdata;
               tuser_q <= 1'b0;
               tlast_q <= (len_q == PW'(1));
               valid_q <= 1'b1;
               copy_q  <= COPY_FIRST;
               st_q    <= ST_PASS_B;
            end
            ST_PASS_B: begin
               if (down_fire) begin
                  if (copy_q == COPY_FIRST) begin
                     copy_q <= COPY_SECOND;
                  end else if (tlast_q) begin
                     valid_q  <= 1'b0;
                     copy_q   <= COPY_FIRST;
                     wr_ptr_q <= '0;
                     st_q     <= ST_PASS_A;
                  end else begin
                     data_q   <= ram_rdata;
                     tlast_q  <= (rd_next == len_q - PW'(1));
                     rd_ptr_q <= rd_next;
                     copy_q   <= COPY_FIRST;
                  end
               end
            end
            default: st_q <= RESET_STATE;
         endcase

         // Live-pixel load overrides the hold release above (bypass path).
         if (accept_line) begin
            data_q  <= up_data;
            tuser_q <= up_tuser;
            tlast_q <= up_tlast;
            valid_q <= 1'b1;
            copy_q  <= COPY_FIRST;
            st_q    <= ST_PASS_A;
            if (wr_ptr_q < MAX_PTR) wr_ptr_q <= wr_ptr_q + PW'(1);
            else                    err_q    <= 1'b1;
         end
      end
   end

   assign down_data    = data_q;
   assign down_valid   = valid_q;
   assign down_tuser   = (copy_q == COPY_FIRST)  ? tuser_q : 1'b0;
   assign down_tlast   = (copy_q == COPY_SECOND) ? tlast_q : 1'b0;
   assign err_overflow = err_q;

endmodule

// File: tb/tb_video_upscaler_2x2.sv
// Directed bench for video_upscaler_2x2 (line buffer depth 4 to reach overflow).
module tb_video_upscaler_2x2;

   localparam int unsigned DW = 8;
   localparam int unsigned ML = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] up_data = '0;
   logic          up_tuser = 1'b0, up_tlast = 1'b0, up_valid = 1'b0;
   logic          up_ready;
   logic [DW-1:0] down_data;
   logic          down_tuser, down_tlast, down_valid;
   logic          down_ready = 1'b1;
   logic          err_overflow;

   always #5 clk = ~clk;

   video_upscaler_2x2 #(
      .D_WIDTH  (DW),
      .MAX_LINE (ML)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .up_data      (up_data),
      .up_tuser     (up_tuser),
      .up_tlast     (up_tlast),
      .up_valid     (up_valid),
      .up_ready     (up_ready),
      .down_data    (down_data),
      .down_tuser   (down_tuser),
      .down_tlast   (down_tlast),
      .down_valid   (down_valid),
      .down_ready   (down_ready),
      .err_overflow (err_overflow)
   );

   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   int unsigned cyc = 0;
   bit          bp_mode = 1'b0;
   logic [9:0]  obs_q[$];
   int unsigned obs_t[$];
   logic [9:0]  exp_q[$];
   logic        prev_stall = 1'b0;
   logic [9:0]  prev_out = '0;

   // Output monitor: records {tuser,tlast,data} per transfer and checks stall stability.
   always @(negedge clk) begin
      cyc++;
      if (!rst) begin
         if (prev_stall && down_valid) begin
            n_vec++;
            assert ({down_tuser, down_tlast, down_data} === prev_out) else begin
               n_err++;
               $error("FAIL stall_hold observed=%h expected=%h",
                      {down_tuser, down_tlast, down_data}, prev_out);
            end
         end
         prev_stall = down_valid & !down_ready;
         prev_out   = {down_tuser, down_tlast, down_data};
         if (down_valid && down_ready) begin
            obs_q.push_back({down_tuser, down_tlast, down_data});
            obs_t.push_back(cyc);
         end
      end else begin
         prev_stall = 1'b0;
      end
   end

   // Sink backpressure pattern 1,0,0,1 when enabled.
   initial begin
      int unsigned idx;
      logic [3:0]  pat;
      idx = 0;
      pat = 4'b1001;
      forever begin
         @(posedge clk);
         #1;
         if (bp_mode) begin
            down_ready = pat[3-idx];
            idx = (idx + 1) % 4;
         end else begin
            down_ready = 1'b1;
            idx = 0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      assert (obs === expv) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic send(input logic [DW-1:0] d, input logic u, input logic l);
      logic acc;
      up_data  = d;
      up_tuser = u;
      up_tlast = l;
      up_valid = 1'b1;
      acc = 1'b0;
      for (int i = 0; i < 200 && !acc; i++) begin
         @(negedge clk);
         acc = up_ready;
         @(posedge clk);
         #1;
      end
      if (!acc) chk("send_timeout", {31'd0, acc}, 32'd1);
      up_valid = 1'b0;
      up_tuser = 1'b0;
      up_tlast = 1'b0;
   endtask

   // One input pixel yields two output replicas: tuser on the first, tlast on the second.
   task automatic px(input logic [DW-1:0] d, input logic u, input logic l);
      exp_q.push_back({u, 1'b0, d});
      exp_q.push_back({1'b0, l, d});
   endtask

   task automatic wait_out(input int unsigned n);
      for (int i = 0; i < 400 && obs_q.size() < n; i++) @(posedge clk);
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic check_stream(input string tag);
      logic [9:0] o;
      chk({tag, "_count"}, obs_q.size(), exp_q.size());
      for (int unsigned i = 0; i < exp_q.size(); i++) begin
         o = (i < obs_q.size()) ? obs_q[i] : 10'bx;
         chk($sformatf("%s_px%0d", tag, i), {22'd0, o}, {22'd0, exp_q[i]});
      end
      obs_q.delete();
      obs_t.delete();
      exp_q.delete();
   endtask

   task automatic frame_2x2();
      send(8'd10, 1'b1, 1'b0);
      send(8'd20, 1'b0, 1'b1);
      send(8'd30, 1'b0, 1'b0);
      send(8'd40, 1'b0, 1'b1);
   endtask

   task automatic expect_2x2();
      px(8'd10, 1'b1, 1'b0); px(8'd20, 1'b0, 1'b1);
      px(8'd10, 1'b0, 1'b0); px(8'd20, 1'b0, 1'b1);
      px(8'd30, 1'b0, 1'b0); px(8'd40, 1'b0, 1'b1);
      px(8'd30, 1'b0, 1'b0); px(8'd40, 1'b0, 1'b1);
   endtask

   initial begin
      // Reset values
      repeat (3) @(posedge clk);
      #1;
      chk("rst_down_valid", {31'd0, down_valid}, 32'd0);
      chk("rst_down_data", {24'd0, down_data}, 32'd0);
      chk("rst_down_flags", {30'd0, down_tuser, down_tlast}, 32'd0);
      chk("rst_err", {31'd0, err_overflow}, 32'd0);
      chk("rst_up_ready", {31'd0, up_ready}, 32'd1);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // 2x2 frame, sink always ready
      frame_2x2();
      expect_2x2();
      wait_out(16);
      check_stream("frame");

      // Same frame under 1,0,0,1 backpressure
      bp_mode = 1'b1;
      frame_2x2();
      expect_2x2();
      wait_out(16);
      bp_mode = 1'b0;
      check_stream("bp");

      // 1-pixel line: one FETCH bubble between live and replay pairs
      send(8'd7, 1'b1, 1'b1);
      px(8'd7, 1'b1, 1'b1);
      px(8'd7, 1'b0, 1'b1);
      wait_out(4);
      chk("one_px_gap", (obs_t.size() >= 3) ? obs_t[2] - obs_t[1] : 32'd0, 32'd2);
      check_stream("one_px");

      // Overflow: 6-pixel line into a 4-entry buffer
      chk("pre_ovf_err", {31'd0, err_overflow}, 32'd0);
      for (int i = 1; i <= 6; i++) send(DW'(i), i == 1, i == 6);
      for (int i = 1; i <= 6; i++) px(DW'(i), i == 1, i == 6);
      for (int i = 1; i <= 4; i++) px(DW'(i), 1'b0, i == 4);
      wait_out(20);
      check_stream("ovf");
      chk("ovf_err_set", {31'd0, err_overflow}, 32'd1);
      repeat (5) @(posedge clk);
      #1;
      chk("ovf_err_sticky", {31'd0, err_overflow}, 32'd1);

      // Reset in the middle of the replay line
      send(8'd10, 1'b1, 1'b0);
      send(8'd20, 1'b0, 1'b1);
      wait_out(5);
      #2;
      rst = 1'b1;
      #1;
      chk("midrst_valid", {31'd0, down_valid}, 32'd0);
      chk("midrst_flags", {30'd0, down_tuser, down_tlast}, 32'd0);
      chk("midrst_err", {31'd0, err_overflow}, 32'd0);
      chk("midrst_up_ready", {31'd0, up_ready}, 32'd1);
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
      obs_q.delete();
      obs_t.delete();
      exp_q.delete();

      // Pixels ahead of the first tuser after reset
      send(8'd5, 1'b0, 1'b0);
      send(8'd6, 1'b0, 1'b0);
      frame_2x2();
`ifdef VIDEO_UPSCALER_FRAMELOCK_EN
      expect_2x2();
      wait_out(16);
`else
      px(8'd5, 1'b0, 1'b0); px(8'd6, 1'b0, 1'b0);
      px(8'd10, 1'b1, 1'b0); px(8'd20, 1'b0, 1'b1);
      px(8'd5, 1'b0, 1'b0); px(8'd6, 1'b0, 1'b0);
      px(8'd10, 1'b0, 1'b0); px(8'd20, 1'b0, 1'b1);
      px(8'd30, 1'b0, 1'b0); px(8'd40, 1'b0, 1'b1);
      px(8'd30, 1'b0, 1'b0); px(8'd40, 1'b0, 1'b1);
      wait_out(24);
`endif
      check_stream("post_rst");
      chk("post_rst_err", {31'd0, err_overflow}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
